wb_shadow: RTL

- Writer side of the shadow-register interface that the forwarding unit reads (swa / shas_value / sregwd, plus per-source-register lookups).
- While the E stage is stalled, W-stage register writes retire and leave the pipeline before E can forward them. This block captures those writes in a small associative buffer and serves them to the forwarding unit until the stall releases.
- Sits next to the hazard unit, between W-stage writeback and the E-stage forwarding muxes.

---
 rtl/wb_shadow_if.sv | 34 +++
 rtl/wb_shadow.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_shadow_if.sv
// Bundles the writeback, stall and lookup signals shared by the shadow buffer and the forwarding logic.
// slave = shadow buffer side, master = pipeline/forwarding side.
interface wb_shadow_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            flush;
    logic            stall_e;
    logic            wstat;
    logic            wregwrite;
    logic [AW-1:0]   wdst;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   era1;
    logic [AW-1:0]   era2;
    logic            hit1;
    logic [XLEN-1:0] data1;
    logic            hit2;
    logic [XLEN-1:0] data2;
    logic            shas_value;
    logic [AW-1:0]   swa;
    logic [XLEN-1:0] sregwd;
    logic            full;
    logic            ovf;

    modport slave (
        input  flush, stall_e, wstat, wregwrite, wdst, wd, era1, era2,
        output hit1, data1, hit2, data2, shas_value, swa, sregwd, full, ovf
    );

    modport master (
        output flush, stall_e, wstat, wregwrite, wdst, wd, era1, era2,
        input  hit1, data1, hit2, data2, shas_value, swa, sregwd, full, ovf
    );
endinterface

// File: rtl/wb_shadow.sv
// Shadow buffer for W-stage register writes that retire while E is stalled; serves them to forwarding.
// Latency: captured write visible on lookups next cycle (same cycle when WB_SHADOW_BYPASS_EN is defined).
// Backpressure: full asserts when all DEPTH slots hold distinct registers; writes beyond that are dropped and flagged in sticky ovf.
module wb_shadow #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        reset,
    wb_shadow_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   newest_q, newest_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [AW-1:0]   addr_d [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];

    logic [DEPTH-1:0] valid;
    logic             wvalid;
    logic             full_w;
    logic             wr_match;
    logic [IW-1:0]    match_idx;
    logic [IW-1:0]    alloc_idx;
    logic             byp_vld;

    assign wvalid    = bus.wstat & bus.wregwrite & (bus.wdst != '0);
    assign full_w    = (count_q == CW'(DEPTH));
    assign alloc_idx = IW'(count_q);

    // Slots fill in order from 0, so validity is simply "index below count".
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CW'(i) < count_q);
        end
    end

    always_comb begin
        wr_match  = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_q[i] == bus.wdst)) begin
                wr_match  = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

`ifdef WB_SHADOW_BYPASS_EN
    assign byp_vld = bus.stall_e & wvalid & ~bus.flush & (wr_match | ~full_w);
`else
    assign byp_vld = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        newest_d = newest_q;
        ovf_d    = ovf_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (bus.flush) begin
            state_d  = IDLE;
            count_d  = '0;
            newest_d = '0;
        end else if (state_q == CAPTURE && !bus.stall_e) begin
            state_d  = IDLE;
            count_d  = '0;
            newest_d = '0;
        end else if (bus.stall_e) begin
            state_d = CAPTURE;
            if (wvalid) begin
                if (wr_match) begin
                    data_d[match_idx] = bus.wd;
                    newest_d          = match_idx;
                end else if (!full_w) begin
                    addr_d[alloc_idx] = bus.wdst;
                    data_d[alloc_idx] = bus.wd;
                    count_d           = count_q + 1'b1;
                    newest_d          = alloc_idx;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            newest_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            newest_q <= newest_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // A register is held in at most one slot, so OR-ing masked data yields the unique match.
    always_comb begin
        bus.hit1  = 1'b0;
        bus.data1 = '0;
        bus.hit2  = 1'b0;
        bus.data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_q[i] == bus.era1) && (bus.era1 != '0)) begin
                bus.hit1  = 1'b1;
                bus.data1 = bus.data1 | data_q[i];
            end
            if (valid[i] && (addr_q[i] == bus.era2) && (bus.era2 != '0)) begin
                bus.hit2  = 1'b1;
                bus.data2 = bus.data2 | data_q[i];
            end
        end
        if (byp_vld && (bus.wdst == bus.era1)) begin
            bus.hit1  = 1'b1;
            bus.data1 = bus.wd;
        end
        if (byp_vld && (bus.wdst == bus.era2)) begin
            bus.hit2  = 1'b1;
            bus.data2 = bus.wd;
        end
    end

    always_comb begin
        bus.shas_value = (count_q != '0);
        bus.swa        = '0;
        bus.sregwd     = '0;
        if (count_q != '0) begin
            bus.swa    = addr_q[newest_q];
            bus.sregwd = data_q[newest_q];
        end
        if (byp_vld) begin
            bus.shas_value = 1'b1;
            bus.swa        = bus.wdst;
            bus.sregwd     = bus.wd;
        end
    end

    assign bus.full = full_w;
    assign bus.ovf  = ovf_q;

endmodule
